// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window generator.
package sobel_pkg;

    typedef logic [7:0]  pixel_t;
    typedef logic [71:0] window_t;

    // Byte-lane index of each window position (row-major, p1 = top-left).
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int P3 = 2;
    localparam int P4 = 3;
    localparam int P5 = 4;
    localparam int P6 = 5;
    localparam int P7 = 6;
    localparam int P8 = 7;
    localparam int P9 = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        ACTIVE = 2'd2
    } win_state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage. The read port is combinational on the
// current contents and the write lands on the clock edge, so an access that
// reads and writes the same column in one beat sees the value from before the
// write (read-before-write).
module line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 640,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic          wr_en_i,
    input  pixel_t        wdata_i,
    output pixel_t        rdata_o
);

    pixel_t mem_q [DEPTH];

    // Old contents of the addressed column.
    assign rdata_o = mem_q[addr_i];

    // Write the new pixel at the end of the beat; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator feeding the Sobel block. Two line buffers
// hold the previous two rows; three 3-byte shift registers form the window,
// which is presented directly on window_out.
//
// Handshake: a beat is accepted when pixel_valid is high and either a frame
// is in progress or sof is high; there is no backpressure. window_valid is a
// one-cycle strobe meaning window_out holds a complete interior window.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sof,
    input  logic       pixel_valid,
    input  pixel_t     pixel_in,
    output window_t    window_out,
    output logic       window_valid,
    output logic       frame_done,
    output logic       busy,
    output win_state_t dbg_state
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    win_state_t    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          win_valid_q, win_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          busy_q, busy_d;
    logic [23:0]   sr_q [3];

    logic          accept;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic          last_pix;
    pixel_t        lb0_rd, lb1_rd;

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
        .clk     (clk),
        .addr_i  (cur_col),
        .wr_en_i (accept),
        .wdata_i (pixel_in),
        .rdata_o (lb0_rd)
    );

    // LB1 receives what LB0 held, so it always lags LB0 by one row.
    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .clk     (clk),
        .addr_i  (cur_col),
        .wr_en_i (accept),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    // Next-state: beat acceptance, position counters, FSM and output strobes.
    always_comb begin
        accept       = pixel_valid && (sof || (state_q != IDLE));
        // A sof beat is always (0,0), whatever frame was in progress.
        cur_col      = sof ? '0 : col_q;
        cur_row      = sof ? '0 : row_q;
        last_pix     = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        col_d        = col_q;
        row_d        = row_q;
        state_d      = state_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = last_pix ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
            if (last_pix) begin
                state_d = IDLE;
            end else if (row_d >= ROW_TWO) begin
                state_d = ACTIVE;
            end else begin
                state_d = FILL;
            end
            // Row/column >= 2 guarantees every shift-register byte belongs
            // to the current frame and the current row span.
            win_valid_d  = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
            frame_done_d = last_pix;
        end
        // Busy covers the frame_done cycle even though the FSM is back in IDLE.
        busy_d = (state_d != IDLE) || frame_done_d;
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    // Window rows shift on each accepted beat, newest byte entering the top lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                sr_q[r] <= '0;
            end
        end else if (accept) begin
            sr_q[0] <= {lb1_rd,   sr_q[0][23:8]};
            sr_q[1] <= {lb0_rd,   sr_q[1][23:8]};
            sr_q[2] <= {pixel_in, sr_q[2][23:8]};
        end
    end

    // Pack the shift registers row-major into the window lanes.
    always_comb begin
        window_out = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                window_out[(P1 + 3 * r + c) * 8 +: 8] = sr_q[r][c * 8 +: 8];
            end
        end
    end

    assign window_valid = win_valid_q;
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 image.
module tb_sobel_window_gen;
    import sobel_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       sof;
    logic       pixel_valid;
    pixel_t     pixel_in;
    window_t    window_out;
    logic       window_valid;
    logic       frame_done;
    logic       busy;
    win_state_t dbg_state;

    always #5 clk = ~clk;

    sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sof          (sof),
        .pixel_valid  (pixel_valid),
        .pixel_in     (pixel_in),
        .window_out   (window_out),
        .window_valid (window_valid),
        .frame_done   (frame_done),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // Hand-computed ramp windows (pixel = 4*row+col), MSB to LSB p9..p1.
    localparam logic [71:0] WIN0 = 72'h0a0908_060504_020100;
    localparam logic [71:0] WIN1 = 72'h0b0a09_070605_030201;
    localparam logic [71:0] WIN2 = 72'h0e0d0c_0a0908_060504;
    localparam logic [71:0] WIN3 = 72'h0f0e0d_0b0a09_070605;
    localparam logic [71:0] WINA = 72'haaaaaa_aaaaaa_aaaaaa;

    typedef struct {
        logic        sof;
        logic        valid;
        logic [7:0]  pix;
        logic        exp_wv;
        logic [71:0] exp_win;
        logic        exp_fd;
        logic        exp_busy;
    } vec_t;

    vec_t tbl [16];

    int errors = 0;
    int checks = 0;
    int fd_count = 0;
    logic [71:0] exp_q [$];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic s, input logic v, input logic [7:0] p);
        sof         = s;
        pixel_valid = v;
        pixel_in    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic push_ramp();
        exp_q.push_back(WIN0);
        exp_q.push_back(WIN1);
        exp_q.push_back(WIN2);
        exp_q.push_back(WIN3);
    endtask

    task automatic run_ramp(input int max_gap);
        int r, c;
        push_ramp();
        for (int k = 0; k < 16; k++) begin
            int g;
            g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int i = 0; i < g; i++) begin
                step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
                chk("gap_wv", 72'(window_valid), 72'(0));
                chk("gap_fd", 72'(frame_done), 72'(0));
            end
            r = k / 4;
            c = k % 4;
            step(k == 0, 1'b1, 8'(k));
            chk("ramp_wv", 72'(window_valid), 72'((r >= 2) && (c >= 2)));
            chk("ramp_fd", 72'(frame_done), 72'(k == 15));
            chk("ramp_busy", 72'(busy), 72'(1));
        end
    endtask

    task automatic end_scenario(input string name, input int fd_before, input int fd_expect);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        chk({name, "_fd_count"}, 72'(fd_count - fd_before), 72'(fd_expect));
        chk({name, "_windows_left"}, 72'(exp_q.size()), 72'(0));
        chk({name, "_idle_busy"}, 72'(busy), 72'(0));
        exp_q.delete();
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (window_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL window_unexpected: got %h expected no strobe", window_out);
            end else begin
                chk("window", window_out, exp_q.pop_front());
            end
        end
        if (frame_done) fd_count++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int fd0;
        for (int k = 0; k < 16; k++) begin
            tbl[k] = '{sof: (k == 0), valid: 1'b1, pix: 8'(k), exp_wv: 1'b0,
                       exp_win: 72'h0, exp_fd: (k == 15), exp_busy: 1'b1};
        end
        tbl[10].exp_wv = 1'b1; tbl[10].exp_win = WIN0;
        tbl[11].exp_wv = 1'b1; tbl[11].exp_win = WIN1;
        tbl[14].exp_wv = 1'b1; tbl[14].exp_win = WIN2;
        tbl[15].exp_wv = 1'b1; tbl[15].exp_win = WIN3;

        rst = 1'b1; sof = 1'b0; pixel_valid = 1'b0; pixel_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_window", window_out, 72'h0);
        chk("rst_wv", 72'(window_valid), 72'(0));
        chk("rst_fd", 72'(frame_done), 72'(0));
        chk("rst_busy", 72'(busy), 72'(0));
        chk("rst_state", 72'(dbg_state), 72'(IDLE));
        rst = 1'b0;
        step(1'b0, 1'b0, 8'd0);

        // Ramp frame, table-driven.
        fd0 = fd_count;
        push_ramp();
        for (int k = 0; k < 16; k++) begin
            step(tbl[k].sof, tbl[k].valid, tbl[k].pix);
            chk("tbl_wv", 72'(window_valid), 72'(tbl[k].exp_wv));
            if (tbl[k].exp_wv) chk("tbl_win", window_out, tbl[k].exp_win);
            chk("tbl_fd", 72'(frame_done), 72'(tbl[k].exp_fd));
            chk("tbl_busy", 72'(busy), 72'(tbl[k].exp_busy));
        end
        end_scenario("ramp", fd0, 1);

        // Random gaps.
        fd0 = fd_count;
        run_ramp(3);
        end_scenario("gaps", fd0, 1);

        // Beats before sof are ignored.
        fd0 = fd_count;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
            chk("presof_busy", 72'(busy), 72'(0));
            chk("presof_wv", 72'(window_valid), 72'(0));
            chk("presof_state", 72'(dbg_state), 72'(IDLE));
        end
        run_ramp(0);
        end_scenario("presof", fd0, 1);

        // Abort by sof at (2,3), then a constant frame.
        fd0 = fd_count;
        exp_q.push_back(WIN0);
        for (int k = 0; k < 11; k++) step(k == 0, 1'b1, 8'(k));
        for (int i = 0; i < 4; i++) exp_q.push_back(WINA);
        for (int k = 0; k < 16; k++) begin
            step(k == 0, 1'b1, 8'haa);
            chk("abort_fd", 72'(frame_done), 72'(k == 15));
        end
        end_scenario("abort", fd0, 1);

        // Reset during row 3, then a clean ramp frame.
        fd0 = fd_count;
        exp_q.push_back(WIN0);
        exp_q.push_back(WIN1);
        for (int k = 0; k < 14; k++) step(k == 0, 1'b1, 8'(k));
        rst = 1'b1;
        step(1'b0, 1'b1, 8'd14);
        chk("midrst_window", window_out, 72'h0);
        chk("midrst_wv", 72'(window_valid), 72'(0));
        chk("midrst_fd", 72'(frame_done), 72'(0));
        chk("midrst_busy", 72'(busy), 72'(0));
        chk("midrst_state", 72'(dbg_state), 72'(IDLE));
        rst = 1'b0;
        run_ramp(0);
        end_scenario("midrst", fd0, 1);

        // Back-to-back frames.
        fd0 = fd_count;
        run_ramp(0);
        run_ramp(0);
        end_scenario("b2b", fd0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
